// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider result stage.
// Optional feature macro: DIV_ZERO_DETECT_EN (adds the div_zero flag to result entries).
package div_pkg;

    // Default operand width of the divider datapath
    localparam int DIV_WIDTH = 16;

    // Result stage control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIX  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    // One finished division result as seen by the consumer
    typedef struct packed {
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
        logic                 div_zero;
`endif
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding finished division results.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [DW-1:0]            i_wr_data,
    input  logic                     i_rd_en,
    output logic [DW-1:0]            o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    // Writes into a full FIFO and reads from an empty one are ignored
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rptr];

    // Storage and pointers; entries are cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy; a simultaneous read and write leaves it unchanged
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/non_restoring_division_result_stage.sv
// Result stage of the non-restoring divider: captures the raw quotient and
// signed remainder, adds the divisor back when the remainder is negative,
// and buffers finished results for a valid/ready consumer.
// Optional feature macro: DIV_ZERO_DETECT_EN (zero-divisor flagging).
module non_restoring_division_result_stage
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_quotient,
    input  logic [WIDTH:0]   in_remainder,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
`ifdef DIV_ZERO_DETECT_EN
    output logic             out_div_zero,
`endif
    output logic             busy
);

`ifdef DIV_ZERO_DETECT_EN
    localparam int DZ_W = 1;
`else
    localparam int DZ_W = 0;
`endif
    localparam int ENTRY_W = 2 * WIDTH + DZ_W;
    localparam int CW      = $clog2(DEPTH) + 1;

    state_t             r_state;
    logic               r_busy;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_div;
`ifdef DIV_ZERO_DETECT_EN
    logic               r_dz;
`endif

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic [WIDTH-1:0]   w_push_quot;

    // Accept only from IDLE and only while a FIFO slot is guaranteed free
    assign in_ready = (r_state == ST_IDLE) && (w_count < CW'(DEPTH));
    assign busy     = r_busy;

    // PUSH never finds the FIFO full in legal use; holding there is just a safe fallback
    assign w_push = (r_state == ST_PUSH) && !w_full;
    assign w_pop  = out_valid && out_ready;

`ifdef DIV_ZERO_DETECT_EN
    assign w_push_quot = r_dz ? '1 : r_quot;
    assign w_wr_data   = {w_push_quot, r_rem[WIDTH-1:0], r_dz};
    assign out_div_zero = w_rd_data[0];
`else
    assign w_push_quot = r_quot;
    assign w_wr_data   = {w_push_quot, r_rem[WIDTH-1:0]};
`endif

    // Head of the FIFO drives the consumer side directly from registers
    assign out_valid     = !w_empty;
    assign out_quotient  = w_rd_data[ENTRY_W-1 -: WIDTH];
    assign out_remainder = w_rd_data[DZ_W +: WIDTH];

    // Capture / restore / push sequencing with registered busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_quot <= in_quotient;
                        r_rem  <= in_remainder;
                        r_div  <= in_divisor;
                        r_busy <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                        // A zero divisor has nothing meaningful to add back
                        r_dz    <= (in_divisor == '0);
                        r_state <= (in_divisor != '0 && in_remainder[WIDTH]) ? ST_FIX : ST_PUSH;
`else
                        r_state <= in_remainder[WIDTH] ? ST_FIX : ST_PUSH;
`endif
                    end
                end
                ST_FIX: begin
                    // Wraps modulo 2^(WIDTH+1); legal inputs always land non-negative
                    r_rem   <= r_rem + {1'b0, r_div};
                    r_state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (!w_full) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    result_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .i_rst_n   (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_non_restoring_division_result_stage.sv
// Self-checking bench for non_restoring_division_result_stage.
// Honours DIV_ZERO_DETECT_EN when defined for the build.
module tb_non_restoring_division_result_stage;
    import div_pkg::*;

    localparam int W = 16;
    localparam int D = 2;
    localparam int N_RND = 60;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_quotient = '0;
    logic [W:0]   in_remainder = '0;
    logic [W-1:0] in_divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic         out_div_zero;
`endif
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;
    result_t exp_q[$];

    always #5 clk = ~clk;

    non_restoring_division_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_quotient   (in_quotient),
        .in_remainder  (in_remainder),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
`ifdef DIV_ZERO_DETECT_EN
        .out_div_zero  (out_div_zero),
`endif
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse one result as soon as in_ready allows; returns at the negedge after capture
    task automatic send(input logic [W-1:0] q, input logic [W:0] r, input logic [W-1:0] d);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            cyc();
            t++;
        end
        chk("send_in_ready", in_ready, 1);
        in_valid     = 1'b1;
        in_quotient  = q;
        in_remainder = r;
        in_divisor   = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [W-1:0] q, input logic [W-1:0] r);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_quot"}, out_quotient, q);
        chk({tag, "_rem"}, out_remainder, r);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] dvd, dvs, qq, rr;
        logic [W:0]   raw;
        result_t      e;
        int           sent, cycles;

        // ---- reset state ----
        cyc();
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_quot", out_quotient, 0);
        chk("rst_out_rem", out_remainder, 0);
`ifdef DIV_ZERO_DETECT_EN
        chk("rst_out_dz", out_div_zero, 0);
`endif
        rst = 1'b1;
        cyc();
        chk("rst_in_ready", in_ready, 1);

        // ---- positive remainder: written at E1 ----
        send(16'd14, 17'h00002, 16'd7);
        chk("pos_e0_busy", busy, 1);
        chk("pos_e0_in_ready", in_ready, 0);
        chk("pos_e0_out_valid", out_valid, 0);
        cyc();
        head("pos", 16'd14, 16'd2);
        chk("pos_e1_busy", busy, 0);
        chk("pos_e1_in_ready", in_ready, 1);
        pop_one();
        chk("pos_drained", out_valid, 0);

        // ---- negative remainder: restored, written at E2 ----
        send(16'd14, 17'h1FFFB, 16'd7);
        chk("neg_e0_out_valid", out_valid, 0);
        cyc();
        chk("neg_e1_out_valid", out_valid, 0);
        chk("neg_e1_busy", busy, 1);
        chk("neg_e1_in_ready", in_ready, 0);
        cyc();
        head("neg", 16'd14, 16'd2);
        chk("neg_e2_in_ready", in_ready, 1);
        pop_one();

        // ---- backpressure: two stored, in_ready held low, drained in order ----
        send(16'd100, 17'h00005, 16'd9);
        send(16'd200, 17'h1FFFE, 16'd9);
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_busy", busy, 0);
            cyc();
        end
        out_ready = 1'b1;
        head("bp_first", 16'd100, 16'd5);
        cyc();
        head("bp_second", 16'd200, 16'd7);
        cyc();
        chk("bp_empty", out_valid, 0);
        out_ready = 1'b0;
        send(16'd300, 17'h00003, 16'd9);
        cyc();
        head("bp_third", 16'd300, 16'd3);
        pop_one();

        // ---- simultaneous read and write with one entry stored ----
        send(16'd1, 17'h00001, 16'd3);
        cyc();
        head("rw_before", 16'd1, 16'd1);
        send(16'd2, 17'h00002, 16'd3);
        out_ready = 1'b1;
        cyc();
        head("rw_after", 16'd2, 16'd2);
        cyc();
        chk("rw_count_one", out_valid, 0);
        out_ready = 1'b0;

        // ---- zero divisor ----
`ifdef DIV_ZERO_DETECT_EN
        send(16'h1234, 17'h00064, 16'd0);
        cyc();
        head("dz", 16'hFFFF, 16'd100);
        chk("dz_flag", out_div_zero, 1);
        pop_one();
        send(16'd5, 17'h00007, 16'd3);
        cyc();
        head("dz_clear", 16'd5, 16'd7);
        chk("dz_flag_clear", out_div_zero, 0);
        pop_one();
`else
        send(16'd5, 17'h00064, 16'd0);
        cyc();
        head("zdiv_pos", 16'd5, 16'd100);
        pop_one();
        send(16'd6, 17'h1FFFB, 16'd0);
        cyc();
        chk("zdiv_fix_pending", out_valid, 0);
        cyc();
        head("zdiv_neg", 16'd6, 16'hFFFB);
        pop_one();
`endif

        // ---- reset while in FIX ----
        send(16'd14, 17'h1FFFB, 16'd7);
        rst = 1'b0;
        cyc();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b1;
        cyc();
        chk("mid_rel_in_ready", in_ready, 1);
        chk("mid_rel_busy", busy, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_emit", out_valid, 0);
            cyc();
        end
        out_ready = 1'b0;

        // ---- randomized traffic against a division reference ----
        sent   = 0;
        cycles = 0;
        while ((sent < N_RND || exp_q.size() != 0) && cycles < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_quot", out_quotient, e.quotient);
                    chk("rnd_rem", out_remainder, e.remainder);
`ifdef DIV_ZERO_DETECT_EN
                    chk("rnd_dz", out_div_zero, e.div_zero);
`endif
                end
            end
            in_valid = 1'b0;
            if (sent < N_RND && in_ready && $urandom_range(0, 1) == 1) begin
                dvd = 16'($urandom_range(0, 65535));
                dvs = 16'($urandom_range(1, 65535));
`ifdef DIV_ZERO_DETECT_EN
                if ($urandom_range(0, 7) == 0) dvs = '0;
`endif
                if (dvs == '0) begin
                    qq  = 16'($urandom_range(0, 65535));
                    raw = {1'b0, dvd};
`ifdef DIV_ZERO_DETECT_EN
                    e.div_zero = 1'b1;
`endif
                    e.quotient  = 16'hFFFF;
                    e.remainder = dvd;
                end else begin
                    qq = dvd / dvs;
                    rr = dvd % dvs;
                    // Non-restoring datapath may leave remainder - divisor instead
                    raw = ($urandom_range(0, 1) == 1) ? ({1'b0, rr} - {1'b0, dvs}) : {1'b0, rr};
`ifdef DIV_ZERO_DETECT_EN
                    e.div_zero = 1'b0;
`endif
                    e.quotient  = qq;
                    e.remainder = rr;
                end
                in_valid     = 1'b1;
                in_quotient  = qq;
                in_remainder = raw;
                in_divisor   = dvs;
                exp_q.push_back(e);
                sent++;
            end
            cyc();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_all_sent", sent, N_RND);
        chk("rnd_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
